// File: rtl/fifo_frame_writer_if.sv
// Source byte handshake and FIFO write port of the frame writer.
// The master modport is the writer's view; slave is the surrounding logic.
interface fifo_frame_writer_if;
    logic [7:0] src_data;
    logic       src_valid;
    logic       src_last;
    logic       src_ready;
    logic       fifo_full;
    logic [7:0] fifo_data;
    logic       fifo_we;

    modport master (
        input  src_data, src_valid, src_last, fifo_full,
        output src_ready, fifo_data, fifo_we
    );

    modport slave (
        output src_data, src_valid, src_last, fifo_full,
        input  src_ready, fifo_data, fifo_we
    );
endinterface

// File: rtl/fifo_frame_writer.sv
// Frames a source byte stream into the async FIFO: payload, length byte, XOR checksum byte.
// Writes are combinational from the current state; only state and accumulators are registered.
module fifo_frame_writer #(
    parameter int MAX_LEN = 64,
    parameter int CNT_W   = 16
) (
    input  logic                 clk_write,
    input  logic                 rst,
    input  logic                 enable,
    fifo_frame_writer_if.master  bus,
    output logic [CNT_W-1:0]     frame_count,
    output logic                 trunc_err
);
    typedef enum logic [1:0] {
        S_PAYLOAD = 2'd0,
        S_LEN     = 2'd1,
        S_CSUM    = 2'd2
    } state_t;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t           state_q;
    logic [7:0]       len_q;
    logic [7:0]       csum_q;
    logic [CNT_W-1:0] frame_count_q;
    logic             trunc_q;

    logic             src_ready_c;
    logic             fifo_we_c;
    logic [7:0]       fifo_data_c;
    logic [7:0]       len_inc;

    assign len_inc = len_q + 8'd1;

    // Outputs are forced low while reset is held so nothing leaks into the FIFO.
    always_comb begin
        src_ready_c = 1'b0;
        fifo_we_c   = 1'b0;
        fifo_data_c = 8'd0;
        if (rst) begin
            case (state_q)
                S_PAYLOAD: begin
                    src_ready_c = enable & ~bus.fifo_full;
                    fifo_data_c = bus.src_data;
                    fifo_we_c   = bus.src_valid & enable & ~bus.fifo_full;
                end
                S_LEN: begin
                    fifo_data_c = len_q;
                    fifo_we_c   = ~bus.fifo_full;
                end
                S_CSUM: begin
                    fifo_data_c = csum_q;
                    fifo_we_c   = ~bus.fifo_full;
                end
                default: begin
                    fifo_we_c = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_write or negedge rst) begin
        if (!rst) begin
            state_q       <= S_PAYLOAD;
            len_q         <= 8'd0;
            csum_q        <= 8'd0;
            frame_count_q <= '0;
            trunc_q       <= 1'b0;
        end else begin
            case (state_q)
                S_PAYLOAD: begin
                    if (fifo_we_c) begin
                        len_q  <= len_inc;
                        csum_q <= csum_q ^ bus.src_data;
                        // An explicit last byte wins over the length limit, so no truncation flag then.
                        if (bus.src_last || (len_inc == MAX_LEN_B)) begin
                            state_q <= S_LEN;
                            if (!bus.src_last) begin
                                trunc_q <= 1'b1;
                            end
                        end
                    end
                end
                S_LEN: begin
                    if (fifo_we_c) begin
                        csum_q  <= csum_q ^ len_q;
                        state_q <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (fifo_we_c) begin
                        frame_count_q <= frame_count_q + 1'b1;
                        len_q         <= 8'd0;
                        csum_q        <= 8'd0;
                        state_q       <= S_PAYLOAD;
                    end
                end
                default: begin
                    state_q <= S_PAYLOAD;
                end
            endcase
        end
    end

    assign bus.src_ready = src_ready_c;
    assign bus.fifo_we   = fifo_we_c;
    assign bus.fifo_data = fifo_data_c;
    assign frame_count   = frame_count_q;
    assign trunc_err     = trunc_q;
endmodule

// File: tb/tb_fifo_frame_writer.sv
// Bench for fifo_frame_writer: directed scenarios plus randomized streams checked
// against a frame-level reference model built from the source byte list.
module tb_fifo_frame_writer;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = 2;

    logic             clk_write = 1'b0;
    logic             rst       = 1'b1;
    logic             enable    = 1'b0;
    logic [CNT_W-1:0] frame_count;
    logic             trunc_err;

    fifo_frame_writer_if bif();

    fifo_frame_writer #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk_write   (clk_write),
        .rst         (rst),
        .enable      (enable),
        .bus         (bif.master),
        .frame_count (frame_count),
        .trunc_err   (trunc_err)
    );

    always #5 clk_write = ~clk_write;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] tx_data[$];
    logic       tx_last[$];
    int         exp_frames = 0;
    logic       exp_trunc  = 1'b0;
    int         full_viol  = 0;

    // Monitor: one line per FIFO write.
    always @(negedge clk_write) begin
        if (rst === 1'b1 && bif.fifo_we === 1'b1) begin
            got_q.push_back(bif.fifo_data);
            if (bif.fifo_full !== 1'b0) full_viol++;
            $display("[TB] fifo write 0x%02h", bif.fifo_data);
        end
    end

    // Reference model: split the byte list into frames and append length and checksum.
    function automatic void model_build();
        int   n = 0;
        logic [7:0] x = 8'd0;
        for (int i = 0; i < tx_data.size(); i++) begin
            exp_q.push_back(tx_data[i]);
            n++;
            x ^= tx_data[i];
            if (tx_last[i] || n == MAX_LEN) begin
                if (!tx_last[i]) exp_trunc = 1'b1;
                exp_q.push_back(8'(n));
                exp_q.push_back(x ^ 8'(n));
                exp_frames++;
                n = 0;
                x = 8'd0;
            end
        end
        tx_data.delete();
        tx_last.delete();
    endfunction

    task automatic drive_idle();
        bif.src_valid = 1'b0;
        bif.src_last  = 1'b0;
        bif.src_data  = 8'd0;
        bif.fifo_full = 1'b0;
        enable        = 1'b1;
    endtask

    task automatic clear_model();
        got_q.delete();
        exp_q.delete();
        tx_data.delete();
        tx_last.delete();
        exp_frames = 0;
        exp_trunc  = 1'b0;
        full_viol  = 0;
    endtask

    task automatic do_reset();
        @(posedge clk_write); #1;
        drive_idle();
        rst = 1'b0;
        repeat (2) @(posedge clk_write);
        #1 rst = 1'b1;
        clear_model();
    endtask

    // Feeds tx_data/tx_last (after model_build has copied them) until all expected writes appear.
    task automatic run_stream(input logic [7:0] bytes_d[$], input logic bytes_l[$],
                              input int full_pct, input int valid_pct, input int en_pct);
        int idx = 0;
        int budget = 0;
        while ((got_q.size() < exp_q.size() || idx < bytes_d.size()) && budget < 5000) begin
            @(posedge clk_write); #1;
            bif.fifo_full = ($urandom_range(99) < full_pct);
            enable        = ($urandom_range(99) < en_pct);
            if (idx < bytes_d.size() && $urandom_range(99) < valid_pct) begin
                bif.src_valid = 1'b1;
                bif.src_data  = bytes_d[idx];
                bif.src_last  = bytes_l[idx];
            end else begin
                bif.src_valid = 1'b0;
                bif.src_data  = 8'($urandom);
                bif.src_last  = 1'($urandom);
            end
            @(negedge clk_write);
            if (bif.src_valid && bif.src_ready) idx++;
            budget++;
        end
        if (budget >= 5000) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL stream_timeout: got %0d writes, required %0d", got_q.size(), exp_q.size());
        end
        @(posedge clk_write); #1;
        drive_idle();
        @(negedge clk_write);
    endtask

    task automatic test_reset();
        #2;
        bif.src_valid = 1'b1;
        bif.src_data  = 8'hFF;
        bif.src_last  = 1'b0;
        bif.fifo_full = 1'b0;
        enable        = 1'b1;
        rst           = 1'b0;
        #1;
        tests_run++;
        if ({bif.fifo_we, bif.src_ready, bif.fifo_data} !== 10'h000) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got we=%b ready=%b data=0x%02h, required 0 0 0x00",
                     bif.fifo_we, bif.src_ready, bif.fifo_data);
        end
        tests_run++;
        if (frame_count !== '0 || trunc_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_regs: got count=%0d trunc=%b, required 0 0", frame_count, trunc_err);
        end
        repeat (2) @(posedge clk_write);
        @(negedge clk_write);
        tests_run++;
        if ({bif.fifo_we, bif.src_ready} !== 2'b00 || frame_count !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_held: got we=%b ready=%b count=%0d, required 0 0 0",
                     bif.fifo_we, bif.src_ready, frame_count);
        end
        #1 rst = 1'b1;
        drive_idle();
        clear_model();
    endtask

    task automatic test_basic_frame();
        logic [7:0] b[3] = '{8'h11, 8'h22, 8'h33};
        logic [7:0] tr[2] = '{8'h03, 8'h03};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_write); #1;
            bif.src_valid = 1'b1;
            bif.src_data  = b[i];
            bif.src_last  = (i == 2);
            @(negedge clk_write);
            tests_run++;
            if ({bif.fifo_we, bif.src_ready, bif.fifo_data} !== {2'b11, b[i]}) begin
                tests_failed++;
                $display("[TB] FAIL basic_payload%0d: got we=%b ready=%b data=0x%02h, required 1 1 0x%02h",
                         i, bif.fifo_we, bif.src_ready, bif.fifo_data, b[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_write); #1;
            bif.src_valid = 1'b1;
            bif.src_last  = 1'b0;
            @(negedge clk_write);
            tests_run++;
            if ({bif.fifo_we, bif.src_ready, bif.fifo_data} !== {2'b10, tr[i]}) begin
                tests_failed++;
                $display("[TB] FAIL basic_trailer%0d: got we=%b ready=%b data=0x%02h, required 1 0 0x%02h",
                         i, bif.fifo_we, bif.src_ready, bif.fifo_data, tr[i]);
            end
        end
        @(posedge clk_write); #1;
        bif.src_valid = 1'b0;
        @(negedge clk_write);
        tests_run++;
        if (bif.fifo_we !== 1'b0 || frame_count !== 2'd1) begin
            tests_failed++;
            $display("[TB] FAIL basic_done: got we=%b count=%0d, required 0 1", bif.fifo_we, frame_count);
        end
    endtask

    task automatic test_len_stall();
        do_reset();
        tx_data = '{8'h11, 8'h22, 8'h33};
        tx_last = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_write); #1;
            bif.src_valid = 1'b1;
            bif.src_data  = tx_data[i];
            bif.src_last  = tx_last[i];
        end
        model_build();
        @(posedge clk_write); #1;
        bif.src_valid = 1'b0;
        bif.fifo_full = 1'b1;
        for (int g = 0; g < 4; g++) begin
            if (g > 0) begin
                @(posedge clk_write); #1;
            end
            @(negedge clk_write);
            tests_run++;
            if ({bif.fifo_we, bif.src_ready, bif.fifo_data} !== {2'b00, 8'h03}) begin
                tests_failed++;
                $display("[TB] FAIL stall_hold%0d: got we=%b ready=%b data=0x%02h, required 0 0 0x03",
                         g, bif.fifo_we, bif.src_ready, bif.fifo_data);
            end
        end
        @(posedge clk_write); #1;
        bif.fifo_full = 1'b0;
        repeat (3) @(posedge clk_write);
        @(negedge clk_write);
        tests_run++;
        if (got_q.size() != exp_q.size() || full_viol != 0) begin
            tests_failed++;
            $display("[TB] FAIL stall_count: got %0d writes (%0d while full), required %0d (0)",
                     got_q.size(), full_viol, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL stall_byte%0d: got 0x%02h, required 0x%02h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_truncation();
        logic [7:0] want[10] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h00, 8'h05, 8'h06, 8'h02, 8'h01};
        logic [7:0] d[$] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        logic       l[$] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 10; i++) exp_q.push_back(want[i]);
        run_stream(d, l, 0, 100, 100);
        tests_run++;
        if (got_q.size() != 10) begin
            tests_failed++;
            $display("[TB] FAIL trunc_count: got %0d writes, required 10", got_q.size());
        end
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== want[i]) begin
                tests_failed++;
                $display("[TB] FAIL trunc_byte%0d: got 0x%02h, required 0x%02h", i, got_q[i], want[i]);
            end
        end
        tests_run++;
        if (trunc_err !== 1'b1 || frame_count !== 2'd2) begin
            tests_failed++;
            $display("[TB] FAIL trunc_flags: got trunc=%b count=%0d, required 1 2", trunc_err, frame_count);
        end
    endtask

    task automatic test_enable_gap();
        logic [7:0] d[4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            d[i] = 8'($urandom);
            tx_data.push_back(d[i]);
            tx_last.push_back(i == 3);
        end
        model_build();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_write); #1;
            bif.src_valid = 1'b1;
            bif.src_data  = d[i];
            bif.src_last  = 1'b0;
        end
        @(posedge clk_write); #1;
        enable       = 1'b0;
        bif.src_data = d[2];
        for (int g = 0; g < 5; g++) begin
            if (g > 0) begin
                @(posedge clk_write); #1;
            end
            @(negedge clk_write);
            tests_run++;
            if ({bif.fifo_we, bif.src_ready} !== 2'b00) begin
                tests_failed++;
                $display("[TB] FAIL enable_gap%0d: got we=%b ready=%b, required 0 0",
                         g, bif.fifo_we, bif.src_ready);
            end
        end
        @(posedge clk_write); #1;
        enable = 1'b1;
        @(posedge clk_write); #1;
        bif.src_data = d[3];
        bif.src_last = 1'b1;
        @(posedge clk_write); #1;
        bif.src_valid = 1'b0;
        bif.src_last  = 1'b0;
        repeat (2) @(posedge clk_write);
        @(negedge clk_write);
        tests_run++;
        if (got_q.size() != 6 || got_q[4] !== 8'h04) begin
            tests_failed++;
            $display("[TB] FAIL enable_len: got %0d writes len=0x%02h, required 6 0x04",
                     got_q.size(), (got_q.size() > 4) ? got_q[4] : 8'hxx);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL enable_byte%0d: got 0x%02h, required 0x%02h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] want[3] = '{8'hA5, 8'h01, 8'hA4};
        logic [7:0] d[$] = '{8'hA5};
        logic       l[$] = '{1'b1};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_write); #1;
            bif.src_valid = 1'b1;
            bif.src_data  = 8'(8'h40 + i);
            bif.src_last  = 1'b0;
        end
        @(posedge clk_write); #1;
        bif.src_data = 8'h77;
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if ({bif.fifo_we, bif.src_ready} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got we=%b ready=%b, required 0 0", bif.fifo_we, bif.src_ready);
        end
        drive_idle();
        @(posedge clk_write); #1;
        rst = 1'b1;
        clear_model();
        for (int i = 0; i < 3; i++) exp_q.push_back(want[i]);
        run_stream(d, l, 0, 100, 100);
        tests_run++;
        if (got_q.size() != 3 || frame_count !== 2'd1 || trunc_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_restart: got %0d writes count=%0d trunc=%b, required 3 1 0",
                     got_q.size(), frame_count, trunc_err);
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== want[i]) begin
                tests_failed++;
                $display("[TB] FAIL async_byte%0d: got 0x%02h, required 0x%02h", i, got_q[i], want[i]);
            end
        end
    endtask

    task automatic test_count_wrap();
        int seq[5] = '{1, 2, 3, 0, 1};
        logic [7:0] d[$];
        logic       l[$];
        do_reset();
        for (int k = 0; k < 5; k++) begin
            d = '{8'($urandom)};
            l = '{1'b1};
            tx_data = d;
            tx_last = l;
            model_build();
            run_stream(d, l, 0, 100, 100);
            tests_run++;
            if (int'(frame_count) != seq[k]) begin
                tests_failed++;
                $display("[TB] FAIL wrap_count%0d: got %0d, required %0d", k, frame_count, seq[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] d[$];
        logic       l[$];
        int         n;
        do_reset();
        for (int it = 0; it < 6; it++) begin
            d.delete();
            l.delete();
            for (int f = 0; f < int'($urandom_range(1, 4)); f++) begin
                n = $urandom_range(1, 2 * MAX_LEN);
                for (int j = 0; j < n; j++) begin
                    d.push_back(8'($urandom));
                    l.push_back(j == n - 1);
                end
            end
            tx_data = d;
            tx_last = l;
            model_build();
            run_stream(d, l, 30, 70, 80);
        end
        tests_run++;
        if (got_q.size() != exp_q.size() || full_viol != 0) begin
            tests_failed++;
            $display("[TB] FAIL random_count: got %0d writes (%0d while full), required %0d (0)",
                     got_q.size(), full_viol, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL random_byte%0d: got 0x%02h, required 0x%02h", i, got_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (frame_count !== CNT_W'(exp_frames) || trunc_err !== exp_trunc) begin
            tests_failed++;
            $display("[TB] FAIL random_flags: got count=%0d trunc=%b, required %0d %b",
                     frame_count, trunc_err, CNT_W'(exp_frames), exp_trunc);
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_basic_frame();
        test_len_stall();
        test_truncation();
        test_enable_gap();
        test_async_reset();
        test_count_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
